// File: rtl/gcm_ingress.sv
// gcm_ingress: packs a typed 32-bit word stream (IV/AAD/DATA/TAG) into
// 128-bit blocks for the gcm core, enforcing message ordering, the post-IV
// hash-key settle gap and zero-padding of short final blocks.
module gcm_ingress #(
  parameter int unsigned IV_WAIT = 24,
  parameter int unsigned IVW     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_decrypt_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [31:0]  s_data_i,
  input  logic [1:0]   s_type_i,
  input  logic         s_last_i,
  input  logic         s_end_i,
  output logic         gcm_iv_vld_o,
  output logic         gcm_aad_vld_o,
  output logic         gcm_data_vld_o,
  output logic         gcm_tag_vld_o,
  output logic         gcm_end_o,
  output logic [127:0] gcm_data_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IV   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_BODY = 3'd3;
  localparam logic [2:0] S_FLSH = 3'd4;
  localparam logic [2:0] S_DROP = 3'd5;

  localparam int unsigned CW = (IV_WAIT > 1) ? $clog2(IV_WAIT) : 1;

  localparam logic [1:0] T_IV   = 2'd0;
  localparam logic [1:0] T_AAD  = 2'd1;
  localparam logic [1:0] T_DATA = 2'd2;
  localparam logic [1:0] T_TAG  = 2'd3;

  logic [2:0]    state;
  logic [127:0]  pack_q;
  logic [1:0]    widx;
  logic [CW-1:0] cnt;
  logic          live;
  logic          decrypt;
  logic          end_pend;
  logic          seg_open;
  logic [1:0]    cur_type;
  logic          tag_seen;

  logic [127:0]  blk;
  logic          accept;
  logic          closing;
  logic          iv_err;
  logic          body_err;

  assign s_ready_o = live && ((state == S_IDLE) || (state == S_IV) ||
                              (state == S_BODY) || (state == S_DROP));
  assign busy_o    = (state != S_IDLE);
  assign accept    = s_valid_i && s_ready_o;
  assign closing   = s_last_i || s_end_i;

  // IV words must be type 0 and the segment must close exactly on word IVW.
  assign iv_err = (s_type_i != T_IV) || (closing != (widx == 2'(IVW - 1)));

  // Body ordering: no IV, no type change inside a segment, non-decreasing
  // type across segments, TAG only when decrypting and only one block of it.
  assign body_err = (s_type_i == T_IV) ||
                    (seg_open && (s_type_i != cur_type)) ||
                    (!seg_open && (s_type_i < cur_type)) ||
                    ((s_type_i == T_TAG) && (!decrypt || tag_seen));

  // Block image with the incoming word inserted; a fresh block starts from zero
  // so unfilled lower words come out as padding.
  always_comb begin
    blk = (widx == 2'd0) ? '0 : pack_q;
    case (widx)
      2'd0: blk[127:96] = s_data_i;
      2'd1: blk[95:64]  = s_data_i;
      2'd2: blk[63:32]  = s_data_i;
      2'd3: blk[31:0]   = s_data_i;
    endcase
  end

  // s_ready_o must stay low during reset and for the first cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Message sequencer, packer and registered strobe generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pack_q         <= '0;
      widx           <= '0;
      cnt            <= '0;
      decrypt        <= 1'b0;
      end_pend       <= 1'b0;
      seg_open       <= 1'b0;
      cur_type       <= T_AAD;
      tag_seen       <= 1'b0;
      gcm_iv_vld_o   <= 1'b0;
      gcm_aad_vld_o  <= 1'b0;
      gcm_data_vld_o <= 1'b0;
      gcm_tag_vld_o  <= 1'b0;
      gcm_end_o      <= 1'b0;
      gcm_data_o     <= '0;
      err_o          <= 1'b0;
    end else begin
      gcm_iv_vld_o   <= 1'b0;
      gcm_aad_vld_o  <= 1'b0;
      gcm_data_vld_o <= 1'b0;
      gcm_tag_vld_o  <= 1'b0;
      gcm_end_o      <= 1'b0;
      err_o          <= 1'b0;
      case (state)
        S_IDLE, S_IV: begin
          if (accept) begin
            if (iv_err) begin
              err_o <= 1'b1;
              widx  <= '0;
              state <= s_end_i ? S_IDLE : S_DROP;
            end else begin
              if (state == S_IDLE) decrypt <= cfg_decrypt_i;
              if (closing) begin
                gcm_data_o   <= blk;
                gcm_iv_vld_o <= 1'b1;
                widx         <= '0;
                cnt          <= CW'(IV_WAIT - 1);
                end_pend     <= s_end_i;
                seg_open     <= 1'b0;
                cur_type     <= T_AAD;
                tag_seen     <= 1'b0;
                state        <= S_WAIT;
              end else begin
                pack_q <= blk;
                widx   <= widx + 2'd1;
                state  <= S_IV;
              end
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (end_pend) begin
              // IV-only message: end pulse lands exactly when BODY would open.
              gcm_end_o <= 1'b1;
              state     <= S_FLSH;
            end else begin
              state <= S_BODY;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_BODY: begin
          if (accept) begin
            if (body_err) begin
              err_o <= 1'b1;
              widx  <= '0;
              state <= s_end_i ? S_IDLE : S_DROP;
            end else begin
              cur_type <= s_type_i;
              seg_open <= !closing;
              if (closing || (widx == 2'd3)) begin
                gcm_data_o <= blk;
                widx       <= '0;
                case (s_type_i)
                  T_AAD:   gcm_aad_vld_o  <= 1'b1;
                  T_DATA:  gcm_data_vld_o <= 1'b1;
                  T_TAG: begin
                    gcm_tag_vld_o <= 1'b1;
                    tag_seen      <= 1'b1;
                  end
                  default: ;
                endcase
              end else begin
                pack_q <= blk;
                widx   <= widx + 2'd1;
              end
              if (s_end_i) state <= S_FLSH;
            end
          end
        end
        // FLSH spans two cycles: pulse gcm_end_o, then leave while it is high,
        // so s_ready_o stays low through the end pulse.
        S_FLSH: begin
          if (!gcm_end_o) gcm_end_o <= 1'b1;
          else            state     <= S_IDLE;
        end
        S_DROP: begin
          if (accept && s_end_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_ingress.sv
// Directed bench for gcm_ingress: ordering, IV wait, padding, tag rules,
// error recovery, back-to-back messages and reset behaviour.
module tb_gcm_ingress;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_decrypt = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic [1:0]   s_type = '0;
  logic         s_last = 1'b0;
  logic         s_end = 1'b0;
  logic         iv_vld, aad_vld, data_vld, tag_vld, end_vld;
  logic [127:0] gdata;
  logic         busy, err;

  int compared = 0;
  int failed   = 0;

  gcm_ingress #(.IV_WAIT(24), .IVW(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_decrypt_i  (cfg_decrypt),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .s_data_i       (s_data),
    .s_type_i       (s_type),
    .s_last_i       (s_last),
    .s_end_i        (s_end),
    .gcm_iv_vld_o   (iv_vld),
    .gcm_aad_vld_o  (aad_vld),
    .gcm_data_vld_o (data_vld),
    .gcm_tag_vld_o  (tag_vld),
    .gcm_end_o      (end_vld),
    .gcm_data_o     (gdata),
    .busy_o         (busy),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  // Cycle counter and strobe monitor (records counts, cycles and payloads).
  int cyc = 0;
  int n_iv = 0, n_aad = 0, n_data = 0, n_tag = 0, n_end = 0, n_err = 0;
  int c_iv = -1, c_aad = -1, c_data = -1, c_tag = -1, c_end = -1, c_err = -1;
  logic [127:0] d_iv = '0, d_aad = '0, d_data = '0, d_data_prev = '0, d_tag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (iv_vld)   begin n_iv++;   c_iv = cyc;   d_iv = gdata; end
    if (aad_vld)  begin n_aad++;  c_aad = cyc;  d_aad = gdata; end
    if (data_vld) begin n_data++; c_data = cyc; d_data_prev = d_data; d_data = gdata; end
    if (tag_vld)  begin n_tag++;  c_tag = cyc;  d_tag = gdata; end
    if (end_vld)  begin n_end++;  c_end = cyc; end
    if (err)      begin n_err++;  c_err = cyc; end
  end

  // Present one word (caller is at posedge+2); returns the accept cycle.
  task automatic send(input logic [1:0] t, input logic [31:0] d,
                      input logic l, input logic e, output int acc);
    int n;
    n = 0;
    acc = -1;
    s_valid = 1'b1; s_type = t; s_data = d; s_last = l; s_end = e;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      compared++; failed++;
      $display("FAIL send_timeout: s_ready=0 required 1 (word %h)", d);
      s_valid = 1'b0;
    end else begin
      acc = cyc;
    end
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_last = 1'b0; s_end = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_iv(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic e);
    int a;
    send(2'd0, w0, 1'b0, 1'b0, a);
    send(2'd0, w1, 1'b0, 1'b0, a);
    send(2'd0, w2, 1'b1, e, a);
  endtask

  task automatic test_reset;
    #3;
    compared++;
    if ({s_ready, busy, iv_vld, aad_vld, data_vld, tag_vld, end_vld, err} !== 8'h00 || gdata !== '0) begin
      failed++; $display("FAIL reset_outputs: got ready=%b busy=%b data=%h required all 0", s_ready, busy, gdata);
    end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (s_ready !== 1'b0) begin failed++; $display("FAIL reset_ready_release: got %b required 0", s_ready); end
    @(posedge clk); #1;
    compared++;
    if (s_ready !== 1'b1) begin failed++; $display("FAIL reset_ready_rise: got %b required 1", s_ready); end
    #1;
  endtask

  task automatic test_encrypt;
    int a0, a3, d7, a, e0;
    e0 = n_err;
    cfg_decrypt = 1'b0;
    send_iv(32'h11111111, 32'h22222222, 32'h33333333, 1'b0);
    send(2'd1, 32'hA0000000, 1'b0, 1'b0, a0);
    send(2'd1, 32'hA0000001, 1'b0, 1'b0, a);
    send(2'd1, 32'hA0000002, 1'b0, 1'b0, a);
    send(2'd1, 32'hA0000003, 1'b1, 1'b0, a3);
    for (int i = 0; i < 8; i++) send(2'd2, 32'hD0000000 + i, 1'b0, (i == 7), d7);
    idle(6);
    compared++;
    if (d_iv !== 128'h11111111_22222222_33333333_00000000) begin failed++; $display("FAIL enc_iv_payload: got %h required 11111111222222223333333300000000", d_iv); end
    compared++;
    if (a0 !== c_iv + 24) begin failed++; $display("FAIL enc_iv_wait: first AAD accepted at %0d required %0d", a0, c_iv + 24); end
    compared++;
    if (c_aad !== a3 + 1 || d_aad !== 128'hA0000000_A0000001_A0000002_A0000003) begin
      failed++; $display("FAIL enc_aad_block: cyc %0d data %h required cyc %0d data A0000000A0000001A0000002A0000003", c_aad, d_aad, a3 + 1);
    end
    compared++;
    if (d_data_prev !== 128'hD0000000_D0000001_D0000002_D0000003 || d_data !== 128'hD0000004_D0000005_D0000006_D0000007) begin
      failed++; $display("FAIL enc_data_blocks: got %h / %h required D0..D3 / D4..D7", d_data_prev, d_data);
    end
    compared++;
    if (c_data !== d7 + 1 || c_end !== c_data + 1) begin failed++; $display("FAIL enc_end_timing: data %0d end %0d required %0d and %0d", c_data, c_end, d7 + 1, d7 + 2); end
    compared++;
    if (n_err !== e0 || busy !== 1'b0) begin failed++; $display("FAIL enc_clean: errs %0d busy %b required %0d and 0", n_err, busy, e0); end
  endtask

  task automatic test_partial;
    int a;
    send_iv(32'h1, 32'h2, 32'h3, 1'b0);
    send(2'd2, 32'hAAAA0001, 1'b0, 1'b0, a);
    send(2'd2, 32'hAAAA0002, 1'b0, 1'b1, a);
    idle(4);
    compared++;
    if (c_data !== a + 1 || d_data !== 128'hAAAA0001_AAAA0002_00000000_00000000) begin
      failed++; $display("FAIL partial_block: cyc %0d data %h required cyc %0d data AAAA0001AAAA00020000000000000000", c_data, d_data, a + 1);
    end
  endtask

  task automatic test_decrypt_tag;
    int a, t3, nt, ne, t0;
    cfg_decrypt = 1'b1;
    send_iv(32'h4, 32'h5, 32'h6, 1'b0);
    cfg_decrypt = 1'b0;
    for (int i = 0; i < 4; i++) send(2'd2, 32'hC0000000 + i, (i == 3), 1'b0, a);
    for (int i = 0; i < 4; i++) send(2'd3, 32'h7A000000 + i, 1'b0, (i == 3), t3);
    idle(4);
    compared++;
    if (c_tag !== t3 + 1 || d_tag !== 128'h7A000000_7A000001_7A000002_7A000003 || c_end !== c_tag + 1) begin
      failed++; $display("FAIL dec_tag: tag cyc %0d data %h end %0d required %0d, 7A..., %0d", c_tag, d_tag, c_end, t3 + 1, t3 + 2);
    end
    // Same sequence while encrypting: TAG must be rejected.
    nt = n_tag; ne = n_end;
    cfg_decrypt = 1'b0;
    send_iv(32'h4, 32'h5, 32'h6, 1'b0);
    for (int i = 0; i < 4; i++) send(2'd2, 32'hC0000000 + i, (i == 3), 1'b0, a);
    send(2'd3, 32'h7A000000, 1'b0, 1'b0, t0);
    for (int i = 1; i < 4; i++) send(2'd3, 32'h7A000000 + i, 1'b0, (i == 3), t3);
    idle(4);
    compared++;
    if (c_err !== t0 + 1) begin failed++; $display("FAIL enc_tag_err: err at %0d required %0d", c_err, t0 + 1); end
    compared++;
    if (n_tag !== nt || n_end !== ne || t3 !== t0 + 3 || busy !== 1'b0) begin
      failed++; $display("FAIL enc_tag_drop: tags %0d ends %0d last acc %0d busy %b required %0d %0d %0d 0", n_tag, n_end, t3, busy, nt, ne, t0 + 3);
    end
  endtask

  task automatic test_order;
    int a, ae, ne, nd, na;
    // AAD after DATA
    ne = n_end;
    send_iv(32'h7, 32'h8, 32'h9, 1'b0);
    send(2'd2, 32'hD1, 1'b0, 1'b0, a);
    send(2'd2, 32'hD2, 1'b1, 1'b0, a);
    send(2'd1, 32'hA1, 1'b0, 1'b0, ae);
    send(2'd1, 32'hA2, 1'b0, 1'b1, a);
    idle(3);
    compared++;
    if (c_err !== ae + 1 || n_end !== ne || busy !== 1'b0) begin failed++; $display("FAIL order_aad_after_data: err %0d ends %0d busy %b required %0d %0d 0", c_err, n_end, busy, ae + 1, ne); end
    // DATA directly in IDLE
    nd = n_data;
    send(2'd2, 32'hD3, 1'b0, 1'b0, ae);
    send(2'd2, 32'hD4, 1'b0, 1'b1, a);
    idle(3);
    compared++;
    if (c_err !== ae + 1 || n_data !== nd || busy !== 1'b0) begin failed++; $display("FAIL order_data_in_idle: err %0d datas %0d busy %b required %0d %0d 0", c_err, n_data, busy, ae + 1, nd); end
    // type change mid-block
    na = n_aad; nd = n_data;
    send_iv(32'h7, 32'h8, 32'h9, 1'b0);
    send(2'd1, 32'hA3, 1'b0, 1'b0, a);
    send(2'd1, 32'hA4, 1'b0, 1'b0, a);
    send(2'd2, 32'hD5, 1'b0, 1'b0, ae);
    send(2'd2, 32'hD6, 1'b0, 1'b1, a);
    idle(3);
    compared++;
    if (c_err !== ae + 1 || n_aad !== na || n_data !== nd || busy !== 1'b0) begin
      failed++; $display("FAIL order_mid_block_change: err %0d aads %0d datas %0d busy %b required %0d %0d %0d 0", c_err, n_aad, n_data, busy, ae + 1, na, nd);
    end
    // short IV
    send(2'd0, 32'h1, 1'b0, 1'b0, a);
    send(2'd0, 32'h2, 1'b0, 1'b1, ae);
    idle(3);
    compared++;
    if (c_err !== ae + 1 || busy !== 1'b0) begin failed++; $display("FAIL short_iv: err %0d busy %b required %0d 0", c_err, busy, ae + 1); end
  endtask

  task automatic test_back_to_back;
    int a, a0, ne;
    ne = n_end;
    send_iv(32'hB0, 32'hB1, 32'hB2, 1'b1);
    send(2'd0, 32'hC0, 1'b0, 1'b0, a0);
    compared++;
    if (c_end !== c_iv + 24 || n_end !== ne + 1) begin failed++; $display("FAIL iv_only_end: end %0d required %0d", c_end, c_iv + 24); end
    compared++;
    if (a0 !== c_end + 1) begin failed++; $display("FAIL next_iv_accept: accepted %0d required %0d", a0, c_end + 1); end
    send(2'd0, 32'hC1, 1'b0, 1'b0, a);
    send(2'd0, 32'hC2, 1'b1, 1'b0, a);
    send(2'd1, 32'hE0, 1'b0, 1'b1, a);
    idle(4);
    compared++;
    if (d_iv !== 128'h000000C0_000000C1_000000C2_00000000 || d_aad !== 128'h000000E0_00000000_00000000_00000000 || c_aad !== a + 1 || c_end !== a + 2) begin
      failed++; $display("FAIL b2b_message: iv %h aad %h aadcyc %0d end %0d", d_iv, d_aad, c_aad, c_end);
    end
  endtask

  task automatic test_reset_mid;
    int a, nd;
    send_iv(32'h1, 32'h2, 32'h3, 1'b0);
    send(2'd2, 32'hF1, 1'b0, 1'b0, a);
    send(2'd2, 32'hF2, 1'b0, 1'b0, a);
    s_valid = 1'b0;
    nd = n_data;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({s_ready, busy, iv_vld, aad_vld, data_vld, tag_vld, end_vld, err} !== 8'h00 || gdata !== '0) begin
      failed++; $display("FAIL reset_mid_outputs: got ready=%b busy=%b data=%h required all 0", s_ready, busy, gdata);
    end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (s_ready !== 1'b1) begin failed++; $display("FAIL reset_mid_ready: got %b required 1", s_ready); end
    #1;
    idle(3);
    compared++;
    if (n_data !== nd) begin failed++; $display("FAIL reset_mid_stale: data strobes %0d required %0d", n_data, nd); end
    send_iv(32'h1, 32'h2, 32'h3, 1'b0);
    send(2'd2, 32'hF3, 1'b0, 1'b1, a);
    idle(4);
    compared++;
    if (d_data !== 128'h000000F3_00000000_00000000_00000000 || c_data !== a + 1) begin
      failed++; $display("FAIL reset_mid_fresh: data %h cyc %0d required 000000F3000... cyc %0d", d_data, c_data, a + 1);
    end
  endtask

  initial begin
    test_reset;
    test_encrypt;
    test_partial;
    test_decrypt_tag;
    test_order;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/gcm_ingress.md
# gcm_ingress

Upstream front-end for the `gcm` core. It accepts a 32-bit typed word stream (IV, AAD, DATA, TAG), packs it into 128-bit blocks, and drives the core's single-cycle strobes `gcm_iv_vld_i`, `gcm_aad_vld_i`, `gcm_data_vld_i`, `gcm_tag_vld_i` and `gcm_end_i`. It enforces message ordering and the post-IV hash-key settle gap. It also zero-pads short final blocks of a segment.

## Interface

- Parameter `IV_WAIT`, default 24: cycles after the IV strobe before body words are accepted; covers H/J0 computation in the core.
- Parameter `IVW`, default 3: IV length in 32-bit words; fixed 96-bit IV.
- Reset is `rst_n`, asynchronous, active-low. The clock is `clk`.
- Port `clk`, input, 1 bit: clock.
- Port `rst_n`, input, 1 bit: async active-low reset.
- Port `cfg_decrypt_i`, input, 1 bit: message mode; sampled when the first IV word is accepted.
- Port `s_valid_i`, input, 1 bit: input word valid.
- Port `s_ready_o`, output, 1 bit: input word accepted when `s_valid_i & s_ready_o`.
- Port `s_data_i`, input, 32 bits: word; the first word of a block maps to [127:96].
- Port `s_type_i`, input, 2 bits: 0 = IV, 1 = AAD, 2 = DATA, 3 = TAG.
- Port `s_last_i`, input, 1 bit: last word of the current segment (type run); closes the block.
- Port `s_end_i`, input, 1 bit: last word of the message; implies `s_last_i`.
- Port `gcm_iv_vld_o`, output, 1 bit: one-cycle block strobe, IV.
- Port `gcm_aad_vld_o`, output, 1 bit: one-cycle block strobe, AAD.
- Port `gcm_data_vld_o`, output, 1 bit: one-cycle block strobe, DATA.
- Port `gcm_tag_vld_o`, output, 1 bit: one-cycle block strobe, TAG.
- Port `gcm_end_o`, output, 1 bit: one-cycle end-of-message pulse.
- Port `gcm_data_o`, output, 128 bits: block payload, valid with any strobe.
- Port `busy_o`, output, 1 bit: message in progress (state ≠ IDLE).
- Port `err_o`, output, 1 bit: one-cycle protocol-error pulse.

## Operation

**State machine**

- **IDLE:** wait for the first IV word.
- **IV:** collect `IVW` words.
- **WAIT:** run the `IV_WAIT` countdown.
- **BODY:** collect AAD, DATA and TAG.
- **FLUSH:** emit `gcm_end_o`.
- **DROP:** discard words until `s_end_i`.

**Packing**

- A 2-bit word index fills the 128-bit shift buffer MSB-first.
- A block is emitted when 4 words have been accepted, or on `s_last_i`/`s_end_i`.
- Unfilled lower words are zero.

**IV**

- Exactly `IVW` words with type 0.
- Emitted as {w0, w1, w2, 32'h0}.
- The last IV word must carry `s_last_i`, or `s_end_i` for an IV-only message.

**Ordering in BODY**

- AAD* then DATA* then TAG?.
- TAG is legal only if the sampled decrypt = 1; at most one TAG block (4 words).
- A type change is legal only at a segment boundary (the previous word had `s_last_i`).
- Zero-length AAD or DATA segments are allowed.

**Errors** pulse `err_o` and go to DROP, emitting no further strobes for that message:

- a non-IV word in IDLE;
- a wrong IV length;
- an order violation;
- a mid-block type change;
- TAG when encrypting;
- a second TAG block.

In DROP, `s_ready_o` = 1. The word with `s_end_i` returns the block to IDLE with no `gcm_end_o`.

**End of message**

- On acceptance of the `s_end_i` word: the final block strobe, then FLSH, then `gcm_end_o`, then IDLE.
- IV-only message: IV strobe, then WAIT, then `gcm_end_o` after the countdown.

## Timing

**Reset values**

- All outputs 0, including `s_ready_o`.
- `s_ready_o` rises the first `clk` after `rst_n` deasserts (IDLE).

**Acceptance and emission**

- 1 word/cycle sustained; `s_ready_o` stays high while packing.
- The block strobe and `gcm_data_o` are registered. They assert the cycle after the closing word is accepted, for exactly 1 cycle.
- `gcm_data_o` holds its last value otherwise.

**IV wait**

- IV strobe at cycle t.
- `s_ready_o` is low from t through t+IV_WAIT−1 and high at t+IV_WAIT.
- For an IV-only message, `gcm_end_o` is at t+IV_WAIT.

**End and restart**

- `gcm_end_o` is 1 cycle after the final block strobe.
- `s_ready_o` is low in FLSH and high again the cycle after `gcm_end_o`. The earliest next-message IV word is accepted then.

**Mode sampling**

- `cfg_decrypt_i` changes mid-message are ignored.

**Error timing**

- `err_o` asserts the cycle after the offending word is accepted.

**Reset mid-message**

- Immediate return to IDLE; partial buffer discarded; no strobes.

## Test plan

- **Encrypt, 1 AAD + 2 DATA blocks.**
  - Stimulus: IV 3 words, AAD 4 words with `s_last_i`, DATA 8 words with `s_end_i` on the 8th, `IV_WAIT`=24.
  - Required: IV strobe with payload {w0,w1,w2,0}, `s_ready_o` low for 24 cycles, then AAD and DATA strobes each 1 cycle after the 4th word, `gcm_end_o` 1 cycle after the last DATA strobe.
- **Partial block.**
  - Stimulus: DATA 0xAAAA0001, 0xAAAA0002 with `s_end_i`.
  - Required: `gcm_data_o` = 128'hAAAA0001_AAAA0002_00000000_00000000 with `gcm_data_vld_o` = 1.
- **Decrypt with tag.**
  - Stimulus: `cfg_decrypt_i`=1; DATA 4 words with `s_last_i`; TAG 4 words with `s_end_i`.
  - Required: DATA strobe, TAG strobe, then `gcm_end_o`.
  - Same sequence with `cfg_decrypt_i`=0: `err_o` after the first TAG word, no TAG strobe, no `gcm_end_o`.
- **Order violations.**
  - AAD word after DATA: required `err_o` = 1.
  - DATA word directly in IDLE: required `err_o` = 1.
  - Type change after 2 words without `s_last_i`: required `err_o` = 1.
  - In each case, subsequent words up to `s_end_i` are accepted and dropped, and a fresh IV then works normally.
- **IV-only and back-to-back messages.**
  - IV with `s_end_i`: required `gcm_end_o` at t+24.
  - Next IV: required acceptance the cycle after `gcm_end_o`.
- **Reset mid-message.**
  - Stimulus: assert `rst_n`=0 after 2 DATA words.
  - Required: all outputs 0 immediately, `s_ready_o`=1 one cycle after release, no stale strobe.
